aes_round_ctrl: RTL and testbench
=================================

Name: aes_round_ctrl

Overview:
- Sequencer for the AES-128 encryption datapath.
- Steps the external 128-bit state register through the AES round order: initial AddRoundKey; rounds 1..NUM_ROUNDS-1 (SubBytes, ShiftRows, MixColumns, AddRoundKey); final round (SubBytes, ShiftRows, AddRoundKey).
- Drives one-hot stage enables (including sr_enable into the ShiftRows block), the state-register load/mux select and a key-request handshake to the key schedule.
- Sits between the top-level host interface and the combinational round-function blocks.

Parameters:
- NUM_ROUNDS, 10, number of AES rounds; legal values 10, 12, 14.
- RW, 4, width of round_num.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; synchronous, active-high; one clock, sync active-high reset.
- start  in  1  request a new block; sampled only while ready=1.
- key_valid  in  1  key schedule presents round key for round_num this cycle.
- ready  out  1  controller idle, start accepted.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse, block complete.
- load_state  out  1  capture data_in into state register.
- sb_enable  out  1  SubBytes stage active; state register captures SubBytes output.
- sr_enable  out  1  ShiftRows stage active; state register captures ShiftRows output.
- mc_enable  out  1  MixColumns stage active; state register captures MixColumns output.
- ark_enable  out  1  AddRoundKey active; state register captures XOR with key.
- state_sel  out  2  state-register mux: 0 hold, 1 SB, 2 SR/MC per enable, 3 ARK.
- key_req  out  1  round key for round_num requested.
- round_num  out  RW  current round, 0..NUM_ROUNDS.

Behaviour:
- Reset:
  - State goes to IDLE; round_num=0.
  - ready=1; all other outputs 0.
  - A reset mid-operation abandons the block; no done pulse is produced.
- States and transitions:
  - IDLE -> LOAD on start.
  - LOAD -> ARK, 1 cycle, round_num=0.
  - ARK: key_req=1. Holds while key_valid=0.
  - On key_valid=1, ARK asserts ark_enable for that cycle, then:
    - if round_num==NUM_ROUNDS -> DONE;
    - else round_num++ and -> SB.
  - SB -> SR -> MC -> ARK, 1 cycle each.
  - When round_num==NUM_ROUNDS, SR goes directly to ARK, skipping MC.
  - DONE: done=1 for 1 cycle, then -> IDLE.
- ready=1 only in IDLE. start in any other state, including DONE, is ignored and not queued.
- busy=1 in every state except IDLE.
- Exactly one of load_state/sb/sr/mc/ark_enable is high in each non-IDLE, non-DONE cycle. The exception is ARK while waiting, where all are 0 and state_sel=0.
- round_num changes only on the ARK->SB transition. It never exceeds NUM_ROUNDS and wraps to 0 only on reaching IDLE.
- Latency (NUM_ROUNDS=10, key_valid held high): done is high in the 42nd cycle after the start-accepting edge. Each cycle key_valid is low in ARK adds one cycle.
- key_valid outside ARK is ignored.

Optional Feature:
- AES_KEY_TIMEOUT_EN defined:
  - Adds output key_err (1 bit, reset 0) and a 4-bit wait counter, cleared on entry to ARK.
  - If key_valid stays low for 15 consecutive ARK cycles: key_err pulses 1 cycle, FSM -> IDLE, round_num=0, no done.
- Without the macro: ARK waits indefinitely; no key_err port.

Decomposition:
- aes_pkg holds:
  - the ctrl_state_e enum (IDLE, LOAD, ARK, SB, SR, MC, DONE);
  - state_sel encodings SEL_HOLD/SEL_SB/SEL_SRMC/SEL_ARK;
  - AES128_ROUNDS=10, AES192_ROUNDS=12, AES256_ROUNDS=14.
- One sub-module, aes_round_counter: round_num register with clear/increment/last-round flag, RW-parameterised.
- FSM and output decode stay in aes_round_ctrl.

Test Plan:
- Reset mid-round 5 -> next cycle IDLE, ready=1, busy=0, round_num=0, all enables 0, no done.
- start pulse, key_valid tied 1, NUM_ROUNDS=10 -> done high exactly cycle 42. Enable sequence is LOAD, ARK(0), {SB,SR,MC,ARK}x9, SB, SR, ARK(10); mc_enable never high in round 10.
- key_valid low 3 cycles in round 4 ARK -> key_req held, ark_enable=0, state_sel=0 for 3 cycles; done at cycle 45.
- start re-asserted while busy and during DONE -> ignored; exactly one done pulse, then ready=1.
- NUM_ROUNDS=14 instance -> round_num reaches 14, done at cycle 58.
- With AES_KEY_TIMEOUT_EN, key_valid low 15 cycles in round 2 ARK -> key_err 1-cycle pulse, IDLE next cycle, done never asserted.

Source files
------------

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared types and encodings for the AES round controller
package aes_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        ARK  = 3'd2,
        SB   = 3'd3,
        SR   = 3'd4,
        MC   = 3'd5,
        DONE = 3'd6
    } ctrl_state_e;

    localparam logic [1:0] SEL_HOLD = 2'd0;
    localparam logic [1:0] SEL_SB   = 2'd1;
    localparam logic [1:0] SEL_SRMC = 2'd2;
    localparam logic [1:0] SEL_ARK  = 2'd3;

    localparam int AES128_ROUNDS = 10;
    localparam int AES192_ROUNDS = 12;
    localparam int AES256_ROUNDS = 14;

endpackage

// File: rtl/aes_round_counter.sv
// rtl/aes_round_counter.sv - round number register with clear, increment and last-round flag
module aes_round_counter #(
    parameter int RW         = 4,
    parameter int NUM_ROUNDS = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clr,
    input  logic          i_inc,
    output logic [RW-1:0] o_count,
    output logic          o_last
);

    logic [RW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != RW'(NUM_ROUNDS))) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;
    assign o_last  = (r_count == RW'(NUM_ROUNDS));

endmodule

// File: rtl/aes_round_ctrl.sv
// rtl/aes_round_ctrl.sv - AES round sequencer driving stage enables and key requests
// Optional key-wait timeout and key_err output enabled by AES_KEY_TIMEOUT_EN.
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = AES128_ROUNDS,
    parameter int RW         = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          key_valid,
    output logic          ready,
    output logic          busy,
    output logic          done,
    output logic          load_state,
    output logic          sb_enable,
    output logic          sr_enable,
    output logic          mc_enable,
    output logic          ark_enable,
    output logic [1:0]    state_sel,
    output logic          key_req,
`ifdef AES_KEY_TIMEOUT_EN
    output logic          key_err,
`endif
    output logic [RW-1:0] round_num
);

    ctrl_state_e r_state;
    ctrl_state_e w_next;
    logic        r_ready, r_busy, r_done, r_load, r_sb, r_sr, r_mc, r_key_req;
    logic [1:0]  r_sel;
    logic        w_fire, w_last, w_timeout;

    // ARK fires in the same cycle the key shows up, so its enable is not registered.
    assign w_fire = (r_state == ARK) && key_valid;

`ifdef AES_KEY_TIMEOUT_EN
    logic [3:0] r_wait;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait <= '0;
        end else if ((w_next == ARK) && (r_state != ARK)) begin
            r_wait <= '0;
        end else if ((r_state == ARK) && !key_valid) begin
            r_wait <= r_wait + 1'b1;
        end
    end

    assign w_timeout = (r_state == ARK) && !key_valid && (r_wait == 4'd14);
    assign key_err   = w_timeout;
`else
    assign w_timeout = 1'b0;
`endif

    aes_round_counter #(
        .RW         (RW),
        .NUM_ROUNDS (NUM_ROUNDS)
    ) u_round_counter (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_next == IDLE),
        .i_inc   (w_fire && !w_last),
        .o_count (round_num),
        .o_last  (w_last)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = start ? LOAD : IDLE;
            LOAD:    w_next = ARK;
            ARK: begin
                if (key_valid)      w_next = w_last ? DONE : SB;
                else if (w_timeout) w_next = IDLE;
                else                w_next = ARK;
            end
            SB:      w_next = SR;
            SR:      w_next = w_last ? ARK : MC;
            MC:      w_next = ARK;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Registered outputs are decoded from the next state so they line up with r_state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_ready   <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_load    <= 1'b0;
            r_sb      <= 1'b0;
            r_sr      <= 1'b0;
            r_mc      <= 1'b0;
            r_key_req <= 1'b0;
            r_sel     <= SEL_HOLD;
        end else begin
            r_state   <= w_next;
            r_ready   <= (w_next == IDLE);
            r_busy    <= (w_next != IDLE);
            r_done    <= (w_next == DONE);
            r_load    <= (w_next == LOAD);
            r_sb      <= (w_next == SB);
            r_sr      <= (w_next == SR);
            r_mc      <= (w_next == MC);
            r_key_req <= (w_next == ARK);
            case (w_next)
                SB:      r_sel <= SEL_SB;
                SR, MC:  r_sel <= SEL_SRMC;
                default: r_sel <= SEL_HOLD;
            endcase
        end
    end

    assign ready      = r_ready;
    assign busy       = r_busy;
    assign done       = r_done;
    assign load_state = r_load;
    assign sb_enable  = r_sb;
    assign sr_enable  = r_sr;
    assign mc_enable  = r_mc;
    assign key_req    = r_key_req;
    assign ark_enable = w_fire;
    assign state_sel  = w_fire ? SEL_ARK : r_sel;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb/tb_aes_round_ctrl.sv - directed self-checking bench for aes_round_ctrl
module tb_aes_round_ctrl;
    import aes_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       a_start, a_kv, a_ready, a_busy, a_done, a_load, a_sb, a_sr, a_mc, a_ark, a_kreq;
    logic [1:0] a_sel;
    logic [3:0] a_round;
    logic       b_start, b_kv, b_ready, b_busy, b_done, b_load, b_sb, b_sr, b_mc, b_ark, b_kreq;
    logic [1:0] b_sel;
    logic [3:0] b_round;
`ifdef AES_KEY_TIMEOUT_EN
    logic       a_kerr, b_kerr;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    aes_round_ctrl #(.NUM_ROUNDS(10), .RW(4)) dut (
        .clk(clk), .rst(rst), .start(a_start), .key_valid(a_kv),
        .ready(a_ready), .busy(a_busy), .done(a_done), .load_state(a_load),
        .sb_enable(a_sb), .sr_enable(a_sr), .mc_enable(a_mc), .ark_enable(a_ark),
        .state_sel(a_sel), .key_req(a_kreq),
`ifdef AES_KEY_TIMEOUT_EN
        .key_err(a_kerr),
`endif
        .round_num(a_round)
    );

    aes_round_ctrl #(.NUM_ROUNDS(14), .RW(4)) dut14 (
        .clk(clk), .rst(rst), .start(b_start), .key_valid(b_kv),
        .ready(b_ready), .busy(b_busy), .done(b_done), .load_state(b_load),
        .sb_enable(b_sb), .sr_enable(b_sr), .mc_enable(b_mc), .ark_enable(b_ark),
        .state_sel(b_sel), .key_req(b_kreq),
`ifdef AES_KEY_TIMEOUT_EN
        .key_err(b_kerr),
`endif
        .round_num(b_round)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // {load, sb, sr, mc, ark} expected in cycle n after the start-accepting edge
    function automatic logic [4:0] exp_vec(input int n, input int nr);
        if (n == 1) return 5'b10000;
        if (n == 2) return 5'b00001;
        if (n >= 3 && n <= 4*nr-2) begin
            case ((n-3) % 4)
                0:       return 5'b01000;
                1:       return 5'b00100;
                2:       return 5'b00010;
                default: return 5'b00001;
            endcase
        end
        if (n == 4*nr-1) return 5'b01000;
        if (n == 4*nr)   return 5'b00100;
        if (n == 4*nr+1) return 5'b00001;
        return 5'b00000;
    endfunction

    function automatic logic [3:0] exp_round(input int n, input int nr);
        if (n <= 2) return 4'd0;
        if (n <= 4*nr-2) return 4'((n-3)/4 + 1);
        return 4'(nr);
    endfunction

    task automatic run_a(input int stall_len, input bit poke, input bit chk_seq, input int exp_done);
        int n = 0, done_cyc = 0, done_cnt = 0, mc10 = 0, stalled = 0;
        @(negedge clk);
        check("a_ready_before", a_ready, 1);
        a_start = 1'b1;
        a_kv    = 1'b1;
        for (int cyc = 0; cyc < 80; cyc++) begin
            @(negedge clk);
            n++;
            a_start = poke && ((n >= 10 && n <= 12) || a_done);
            if (stall_len > 0 && a_kreq && a_round == 4'd4 && stalled < stall_len) begin
                a_kv = 1'b0;
                stalled++;
            end else begin
                a_kv = 1'b1;
            end
            #1;
            if (!a_kv) begin
                check("stall_key_req", a_kreq, 1);
                check("stall_ark_en", a_ark, 0);
                check("stall_sel", a_sel, 0);
            end
            if (chk_seq && n <= 42)
                check($sformatf("seq_c%0d", n),
                      {a_round, a_load, a_sb, a_sr, a_mc, a_ark, a_done},
                      {exp_round(n, 10), exp_vec(n, 10), (n == 42)});
            if (a_mc && a_round == 4'd10) mc10++;
            if (a_done) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = n;
            end
            if (done_cyc != 0 && n >= done_cyc + 4) break;
        end
        a_start = 1'b0;
        a_kv    = 1'b1;
        check("done_cycle", done_cyc, exp_done);
        check("done_count", done_cnt, 1);
        check("mc_in_last_round", mc10, 0);
        check("stall_cycles", stalled, stall_len);
        check("ready_after", {a_ready, a_busy, a_round}, {1'b1, 1'b0, 4'd0});
    endtask

    task automatic run_b;
        int n = 0, done_cyc = 0, max_round = 0;
        @(negedge clk);
        b_start = 1'b1;
        b_kv    = 1'b1;
        for (int cyc = 0; cyc < 100; cyc++) begin
            @(negedge clk);
            n++;
            b_start = 1'b0;
            #1;
            if (n == 1 || n == 30 || n == 55 || n == 57)
                check($sformatf("seq14_c%0d", n),
                      {b_round, b_load, b_sb, b_sr, b_mc, b_ark},
                      {exp_round(n, 14), exp_vec(n, 14)});
            if (int'(b_round) > max_round) max_round = int'(b_round);
            if (b_done && done_cyc == 0) done_cyc = n;
            if (done_cyc != 0 && n >= done_cyc + 2) break;
        end
        check("r14_max_round", max_round, 14);
        check("r14_done_cycle", done_cyc, 58);
        check("r14_ready_after", b_ready, 1);
    endtask

    task automatic reset_mid_round5;
        int seen = 0, dones = 0;
        @(negedge clk);
        a_start = 1'b1;
        a_kv    = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        for (int cyc = 0; cyc < 60 && a_round != 4'd5; cyc++) @(negedge clk);
        check("reached_round5", a_round, 5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_outputs",
              {a_ready, a_busy, a_done, a_load, a_sb, a_sr, a_mc, a_ark, a_kreq, a_sel, a_round},
              {1'b1, 1'b0, 7'd0, 2'd0, 4'd0});
        for (int cyc = 0; cyc < 5; cyc++) begin
            @(negedge clk);
            if (a_done) dones++;
            if (a_busy) seen++;
        end
        check("rst_mid_no_done", dones, 0);
        check("rst_mid_stays_idle", seen, 0);
    endtask

`ifdef AES_KEY_TIMEOUT_EN
    task automatic timeout_round2;
        int low = 0, err_at = 0, errs = 0, dones = 0;
        @(negedge clk);
        a_start = 1'b1;
        a_kv    = 1'b1;
        for (int cyc = 0; cyc < 80; cyc++) begin
            @(negedge clk);
            a_start = 1'b0;
            if (a_kreq && a_round == 4'd2) begin
                a_kv = 1'b0;
                low++;
            end else begin
                a_kv = 1'b1;
            end
            #1;
            if (a_done) dones++;
            if (a_kerr) begin
                errs++;
                err_at = low;
            end
            if (err_at != 0 && !a_kreq) break;
        end
        a_kv = 1'b1;
        check("kerr_at_low15", err_at, 15);
        check("kerr_pulses", errs, 1);
        check("kerr_no_done", dones, 0);
        check("kerr_idle_after", {a_ready, a_busy, a_round}, {1'b1, 1'b0, 4'd0});
    endtask
`endif

    initial begin
        rst     = 1'b1;
        a_start = 1'b0;
        a_kv    = 1'b0;
        b_start = 1'b0;
        b_kv    = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_a",
              {a_ready, a_busy, a_done, a_load, a_sb, a_sr, a_mc, a_ark, a_kreq, a_sel, a_round},
              {1'b1, 1'b0, 7'd0, 2'd0, 4'd0});
        check("reset_b", {b_ready, b_busy, b_round}, {1'b1, 1'b0, 4'd0});

        run_a(0, 1'b0, 1'b1, 42);
        run_a(3, 1'b0, 1'b0, 45);
        run_a(0, 1'b1, 1'b1, 42);
        run_b();
        reset_mid_round5();
`ifdef AES_KEY_TIMEOUT_EN
        timeout_round2();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
